// File: rtl/io_pkg.sv
// Shared sizing and types for the board input conditioner.
package io_pkg;

    localparam int NUM_BTN          = 4;
    localparam int NUM_SW           = 32;
    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int DEBOUNCE_MAX     = 1 << 20;
    localparam int CNT_W            = $clog2(DEBOUNCE_MAX);

    typedef logic [NUM_BTN-1:0] btn_vec_t;
    typedef logic [NUM_SW-1:0]  sw_vec_t;
    typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-flop synchronizer, polarity fix, hold counter, stable level and press pulse.
module debounce_bit
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_press
);

    localparam cnt_t LAST     = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic [1:0] sync;
    logic       synced;
    cnt_t       cnt;

    // Synchronizer idles at the released level so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= {2{IDLE_LVL}};
        else          sync <= {sync[0], i_raw};
    end

    assign synced = sync[1] ^ ACTIVE_LOW;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            o_stable <= 1'b0;
            o_press  <= 1'b0;
        end else begin
            o_press <= 1'b0;
            if (synced == o_stable) begin
                cnt <= '0;
            end else if (cnt < LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt      <= '0;
                o_stable <= synced;
                o_press  <= synced;
            end
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces raw board switches and buttons for the CPU IO port; adds press pulses and sticky flags.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    input  logic [NUM_BTN-1:0] i_btn_clr,
    output logic [NUM_SW-1:0]  o_io_sw,
    output logic [NUM_BTN-1:0] o_io_btn,
    output logic [NUM_BTN-1:0] o_btn_press,
    output logic [NUM_BTN-1:0] o_btn_sticky
);

    localparam cnt_t LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (BTN_ACTIVE_LOW)
            ) u_db (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_raw    (i_btn_raw[gi]),
                .o_stable (o_io_btn[gi]),
                .o_press  (o_btn_press[gi])
            );
        end
    endgenerate

    // A press arriving together with a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_btn_sticky <= '0;
        else          o_btn_sticky <= o_btn_press | (o_btn_sticky & ~i_btn_clr);
    end

    sw_vec_t sw_sync1, sw_sync2, sw_prev, sw_agree;
    cnt_t    tick_cnt;
    logic    tick;

    assign tick     = (tick_cnt == LAST);
    assign sw_agree = ~(sw_sync2 ^ sw_prev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sw_sync1 <= i_sw_raw;
            sw_sync2 <= sw_sync1;
        end
    end

    // A switch bit moves only when two samples one tick apart agree.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_prev <= '0;
            o_io_sw <= '0;
        end else if (tick) begin
            sw_prev <= sw_sync2;
            o_io_sw <= (sw_sync2 & sw_agree) | (o_io_sw & ~sw_agree);
        end
    end

endmodule
